// File: rtl/stoplight_timed.sv
// Timed Washington Rd / Prospect Ave stoplight: a Moore FSM with an actuated Prospect green.
// Optional pedestrian walk phase: define STOPLIGHT_PED_WALK_EN.
module stoplight_timed #(
   parameter int WASH_MIN = 8,
   parameter int YLW_CYC  = 3,
   parameter int RED_CYC  = 1,
   parameter int PROS_MIN = 4,
   parameter int PROS_MAX = 10,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car_present,
`ifdef STOPLIGHT_PED_WALK_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [2:0] light_pros,
   output logic [2:0] light_wash,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      WASH_GRN = 3'd0,
      WASH_YLW = 3'd1,
      RED_A    = 3'd2,
      PROS_GRN = 3'd3,
      PROS_YLW = 3'd4,
      RED_B    = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] WMIN_L = CNT_W'(WASH_MIN - 1);
   localparam logic [CNT_W-1:0] YLW_L  = CNT_W'(YLW_CYC - 1);
   localparam logic [CNT_W-1:0] RED_L  = CNT_W'(RED_CYC - 1);
   localparam logic [CNT_W-1:0] PMIN_L = CNT_W'(PROS_MIN - 1);
   localparam logic [CNT_W-1:0] PMAX_L = CNT_W'(PROS_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic             car_req;
   logic             req;
   logic             enter_pg;

   assign enter_pg = (state_nx == PROS_GRN) && (state != PROS_GRN);

`ifdef STOPLIGHT_PED_WALK_EN
   localparam logic [CNT_W-1:0] PWALK_L = CNT_W'(PROS_MIN);

   logic ped_pend;
   logic walk_on;

   assign req  = car_present | car_req | ped_pend;
   assign walk = (state == PROS_GRN) && walk_on && (cnt < PWALK_L);

   // Latch pedestrian calls; arm the walk window when Prospect green starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_pend <= 1'b0;
         walk_on  <= 1'b0;
      end else if (enter_pg) begin
         ped_pend <= 1'b0;
         walk_on  <= ped_pend | ped_req;
      end else begin
         if (ped_req)
            ped_pend <= 1'b1;
         if (state_nx != PROS_GRN)
            walk_on <= 1'b0;
      end
   end
`else
   assign req = car_present | car_req;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= WASH_GRN;
      else
         state <= state_nx;
   end

   // Cycles-in-state counter: clears on a state change, saturates otherwise.
   always_ff @(posedge clk) begin
      if (rst || (state_nx != state))
         cnt <= '0;
      else if (cnt != CNT_SAT)
         cnt <= cnt + 1'b1;
   end

   // Remember a car seen outside Prospect green so short pulses are not lost.
   always_ff @(posedge clk) begin
      if (rst)
         car_req <= 1'b0;
      else if (enter_pg)
         car_req <= 1'b0;
      else if (car_present && (state != PROS_GRN))
         car_req <= 1'b1;
   end

   // Next-state logic; illegal encodings fall back to Washington green.
   always_comb begin
      state_nx = state;
      case (state)
         WASH_GRN:
            if (req && (cnt >= WMIN_L))
               state_nx = WASH_YLW;
         WASH_YLW:
            if (cnt == YLW_L)
               state_nx = RED_A;
         RED_A:
            if (cnt == RED_L)
               state_nx = PROS_GRN;
         PROS_GRN:
            if ((cnt >= PMIN_L) && (!car_present || (cnt == PMAX_L)))
               state_nx = PROS_YLW;
         PROS_YLW:
            if (cnt == YLW_L)
               state_nx = RED_B;
         RED_B:
            if (cnt == RED_L)
               state_nx = WASH_GRN;
         default:
            state_nx = WASH_GRN;
      endcase
   end

   // Light decode from the state register only.
   always_comb begin
      light_wash = 3'b001;
      light_pros = 3'b001;
      phase      = state;
      case (state)
         WASH_GRN: light_wash = 3'b100;
         WASH_YLW: light_wash = 3'b010;
         PROS_GRN: light_pros = 3'b100;
         PROS_YLW: light_pros = 3'b010;
         default: begin
            light_wash = 3'b001;
            light_pros = 3'b001;
         end
      endcase
   end

endmodule

// File: tb/tb_stoplight_timed.sv
// Testbench for stoplight_timed: directed scenarios plus random car traffic
// checked against a phase/elapsed-time reference model.
module tb_stoplight_timed;

   localparam int WMIN = 8;
   localparam int YLW  = 3;
   localparam int RED  = 1;
   localparam int PMIN = 4;
   localparam int PMAX = 10;
   localparam int PERIOD = WMIN + PMAX + 2 * YLW + 2 * RED;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       car_present = 1'b0;
   logic [2:0] light_pros;
   logic [2:0] light_wash;
   logic [2:0] phase;
`ifdef STOPLIGHT_PED_WALK_EN
   logic       ped_req = 1'b0;
   logic       walk;
`endif

   int n_run  = 0;
   int n_fail = 0;

   // Reference model: phase index, unbounded elapsed time, latched request.
   int m_ph  = 0;
   int m_t   = 0;
   bit m_req = 1'b0;

   stoplight_timed #(
      .WASH_MIN(WMIN), .YLW_CYC(YLW), .RED_CYC(RED),
      .PROS_MIN(PMIN), .PROS_MAX(PMAX), .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .car_present(car_present),
`ifdef STOPLIGHT_PED_WALK_EN
      .ped_req(ped_req),
      .walk(walk),
`endif
      .light_pros(light_pros),
      .light_wash(light_wash),
      .phase(phase)
   );

   always #5 clk = ~clk;

   // Lamp for a road whose green phase index is g (yellow is g+1).
   function automatic logic [2:0] lamp(input int ph, input int g);
      if (ph == g)
         return 3'b100;
      else if (ph == g + 1)
         return 3'b010;
      return 3'b001;
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, sample after.
   task automatic tick(input logic r, input logic cp);
      bit leave;
      rst = r;
      car_present = cp;
      @(posedge clk);
      if (r) begin
         m_ph = 0;
         m_t = 0;
         m_req = 1'b0;
      end else begin
         case (m_ph)
            0: leave = (cp || m_req) && (m_t >= WMIN - 1);
            1, 4: leave = (m_t == YLW - 1);
            2, 5: leave = (m_t == RED - 1);
            default: leave = (m_t >= PMIN - 1) && (!cp || m_t == PMAX - 1);
         endcase
         if (cp && m_ph != 3)
            m_req = 1'b1;
         if (leave) begin
            m_ph = (m_ph + 1) % 6;
            m_t = 0;
            if (m_ph == 3)
               m_req = 1'b0;
         end else begin
            m_t++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0);
      n_run++;
      if ({phase, light_wash, light_pros} !== {3'd0, 3'b100, 3'b001}) begin
         n_fail++;
         $display("FAIL reset: got ph=%0d w=%b p=%b want ph=0 w=100 p=001",
                  phase, light_wash, light_pros);
      end
   endtask

   task automatic test_idle();
      tick(1'b1, 1'b0);
      for (int k = 0; k < 60; k++) begin
         tick(1'b0, 1'b0);
         n_run++;
         if ({phase, light_wash, light_pros} !== {3'd0, 3'b100, 3'b001}) begin
            n_fail++;
            $display("FAIL idle c%0d: got ph=%0d w=%b p=%b want ph=0 w=100 p=001",
                     k + 1, phase, light_wash, light_pros);
         end
      end
   endtask

   task automatic test_pulse();
      int exp_ph;
      tick(1'b1, 1'b0);
      for (int k = 0; k < 30; k++) begin
         if (k < WMIN) exp_ph = 0;
         else if (k < WMIN + YLW) exp_ph = 1;
         else if (k < WMIN + YLW + RED) exp_ph = 2;
         else if (k < WMIN + YLW + RED + PMIN) exp_ph = 3;
         else if (k < WMIN + 2 * YLW + RED + PMIN) exp_ph = 4;
         else if (k < WMIN + 2 * YLW + 2 * RED + PMIN) exp_ph = 5;
         else exp_ph = 0;
         n_run++;
         if ({phase, light_wash, light_pros} !==
             {3'(exp_ph), lamp(exp_ph, 0), lamp(exp_ph, 3)}) begin
            n_fail++;
            $display("FAIL pulse c%0d: got ph=%0d w=%b p=%b want ph=%0d",
                     k, phase, light_wash, light_pros, exp_ph);
         end
         tick(1'b0, (k == 2));
      end
   endtask

   task automatic test_hold();
      int run;
      int last_wg;
      int prev;
      int periods;
      run = 0;
      last_wg = -1;
      periods = 0;
      tick(1'b1, 1'b0);
      prev = int'(phase);
      for (int k = 1; k < 4 * PERIOD; k++) begin
         tick(1'b0, 1'b1);
         n_run++;
         if (light_wash != 3'b001 && light_pros != 3'b001) begin
            n_fail++;
            $display("FAIL hold overlap c%0d: got w=%b p=%b want one red",
                     k, light_wash, light_pros);
         end
         if (phase == 3'd3) begin
            run++;
         end else if (prev == 3) begin
            n_run++;
            if (run != PMAX) begin
               n_fail++;
               $display("FAIL hold green c%0d: got %0d want %0d", k, run, PMAX);
            end
            run = 0;
         end
         if (phase == 3'd0 && prev == 5) begin
            if (last_wg >= 0) begin
               periods++;
               n_run++;
               if (k - last_wg != PERIOD) begin
                  n_fail++;
                  $display("FAIL hold period: got %0d want %0d", k - last_wg, PERIOD);
               end
            end
            last_wg = k;
         end
         prev = int'(phase);
      end
      n_run++;
      if (periods < 2) begin
         n_fail++;
         $display("FAIL hold periods: got %0d want >=2", periods);
      end
   endtask

   task automatic test_arrival();
      tick(1'b1, 1'b0);
      for (int k = 0; k < 30; k++)
         tick(1'b0, 1'b0);
      n_run++;
      if (phase !== 3'd0) begin
         n_fail++;
         $display("FAIL arrival c30: got ph=%0d want 0", phase);
      end
      tick(1'b0, 1'b1);
      n_run++;
      if ({phase, light_wash} !== {3'd1, 3'b010}) begin
         n_fail++;
         $display("FAIL arrival c31: got ph=%0d w=%b want ph=1 w=010",
                  phase, light_wash);
      end
   endtask

   task automatic test_drop();
      int g;
      int n;
      tick(1'b1, 1'b0);
      n = 0;
      while (phase != 3'd3 && n < 100) begin
         tick(1'b0, 1'b1);
         n++;
      end
      g = 1;
      while (phase == 3'd3 && g < 20) begin
         tick(1'b0, (g < 6));
         if (phase == 3'd3)
            g++;
      end
      n_run++;
      if (g != 6 || phase !== 3'd4) begin
         n_fail++;
         $display("FAIL drop: got green=%0d ph=%0d want green=6 ph=4", g, phase);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      n = 0;
      while (phase != 3'd4 && n < 100) begin
         tick(1'b0, 1'b0);
         n++;
      end
      n_run++;
      if (phase !== 3'd4) begin
         n_fail++;
         $display("FAIL rstmid reach: got ph=%0d want 4", phase);
      end
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      n_run++;
      if ({phase, light_wash, light_pros} !== {3'd0, 3'b100, 3'b001}) begin
         n_fail++;
         $display("FAIL rstmid: got ph=%0d w=%b p=%b want ph=0 w=100 p=001",
                  phase, light_wash, light_pros);
      end
      for (int k = 0; k < 40; k++) begin
         tick(1'b0, 1'b0);
         n_run++;
         if (phase !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid hold c%0d: got ph=%0d want 0", k, phase);
         end
      end
   endtask

   task automatic test_random();
      logic cp;
      logic r;
      int density;
      tick(1'b1, 1'b0);
      for (int k = 0; k < 3000; k++) begin
         density = (k / 500) % 4;
         cp = ($urandom_range(0, 7) < 2 * density);
         r = ($urandom_range(0, 249) == 0);
         tick(r, cp);
         n_run++;
         if ({phase, light_wash, light_pros} !==
             {3'(m_ph), lamp(m_ph, 0), lamp(m_ph, 3)}) begin
            n_fail++;
            $display("FAIL random c%0d: got ph=%0d w=%b p=%b want ph=%0d",
                     k, phase, light_wash, light_pros, m_ph);
         end
         if (light_wash != 3'b001 && light_pros != 3'b001) begin
            n_fail++;
            $display("FAIL random overlap c%0d: got w=%b p=%b", k,
                     light_wash, light_pros);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_pulse();
      test_hold();
      test_arrival();
      test_drop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
